// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: clock generation, 2-FF input sync,
// 3rd-order CIC decimator and a single-entry valid/ready output register.
module pdm_cic_decimator #(
  parameter int CLK_DIV = 50,
  parameter int DECIM   = 64,
  parameter int OUT_W   = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             enable,
  output logic             pdm_clk,
  input  logic             pdm_data,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [31:0]      sample_cnt
);

  localparam int LG    = $clog2(DECIM);
  localparam int ACC_W = 3*LG + 2;
  localparam int SHIFT = 3*LG - (OUT_W-1);
  localparam int HALF  = CLK_DIV/2;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV-1);
  localparam logic [DIV_W-1:0] CAP_CNT  = DIV_W'(HALF-1);
  localparam logic [DIV_W-1:0] HALF_C   = DIV_W'(HALF);

  localparam logic signed [ACC_W-1:0] P_MAX =
    ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] P_MIN = ~P_MAX;

  logic             r_run;
  logic [DIV_W-1:0] r_div;
  logic             r_pclk;
  logic             r_s1;
  logic             r_s2;

  logic signed [ACC_W-1:0] r_i1;
  logic signed [ACC_W-1:0] r_i2;
  logic signed [ACC_W-1:0] r_i3;
  logic [LG-1:0]           r_phase;
  logic                    r_strobe;
  logic signed [ACC_W-1:0] r_d1;
  logic signed [ACC_W-1:0] r_d2;
  logic signed [ACC_W-1:0] r_d3;
  logic signed [ACC_W-1:0] r_comb;
  logic                    r_cvalid;
  logic [1:0]              r_warm;

  logic [OUT_W-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;
  logic [31:0]      r_cnt;

  logic [DIV_W-1:0]        w_div_nxt;
  logic                    w_cap;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_c1;
  logic signed [ACC_W-1:0] w_c2;
  logic signed [ACC_W-1:0] w_c3;
  logic signed [ACC_W-1:0] w_sh;
  logic [OUT_W-1:0]        w_pcm;
  logic                    w_cand;
  logic                    w_xfer;
  logic                    w_drop;

  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
  assign w_cap     = r_run && (r_div == CAP_CNT);
  assign w_x       = r_s2 ? ACC_W'(1) : '1;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_run  <= 1'b0;
      r_div  <= '0;
      r_pclk <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
    end else if (!enable) begin
      r_run  <= 1'b0;
      r_div  <= '0;
      r_pclk <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
    end else begin
      r_s1  <= pdm_data;
      r_s2  <= r_s1;
      r_run <= 1'b1;
      // first enabled edge starts the high phase at count 0
      if (!r_run) begin
        r_div  <= '0;
        r_pclk <= 1'b1;
      end else begin
        r_div  <= w_div_nxt;
        r_pclk <= (w_div_nxt < HALF_C);
      end
    end
  end

  assign w_c1 = r_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_i1 <= '0; r_i2 <= '0; r_i3 <= '0;
      r_phase <= '0; r_strobe <= 1'b0;
      r_d1 <= '0; r_d2 <= '0; r_d3 <= '0;
      r_comb <= '0; r_cvalid <= 1'b0; r_warm <= '0;
    end else if (!enable) begin
      r_i1 <= '0; r_i2 <= '0; r_i3 <= '0;
      r_phase <= '0; r_strobe <= 1'b0;
      r_d1 <= '0; r_d2 <= '0; r_d3 <= '0;
      r_comb <= '0; r_cvalid <= 1'b0; r_warm <= '0;
    end else begin
      r_strobe <= 1'b0;
      r_cvalid <= 1'b0;
      if (w_cap) begin
        r_i1     <= r_i1 + w_x;
        r_i2     <= r_i2 + r_i1;
        r_i3     <= r_i3 + r_i2;
        r_phase  <= r_phase + 1'b1;
        r_strobe <= (r_phase == '1);
      end
      if (r_strobe) begin
        r_d1     <= r_i3;
        r_d2     <= w_c1;
        r_d3     <= w_c2;
        r_comb   <= w_c3;
        r_cvalid <= 1'b1;
      end
      if (r_cvalid && r_warm != 2'd2)
        r_warm <= r_warm + 2'd1;
    end
  end

  assign w_sh = r_comb >>> SHIFT;

  always_comb begin
    w_pcm = w_sh[OUT_W-1:0];
    if (w_sh > P_MAX)
      w_pcm = P_MAX[OUT_W-1:0];
    else if (w_sh < P_MIN)
      w_pcm = P_MIN[OUT_W-1:0];
  end

  // results emitted before two have been discarded are never presented
  assign w_cand = enable && r_cvalid && (r_warm == 2'd2);
  assign w_xfer = r_valid && pcm_ready;
  assign w_drop = w_cand && r_valid && !pcm_ready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer)
        r_cnt <= r_cnt + 32'd1;
      if (w_drop)
        r_ovr <= 1'b1;
      else if (clr_overrun)
        r_ovr <= 1'b0;
      if (!enable) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_cand && (!r_valid || w_xfer)) begin
        r_data  <= w_pcm;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign pdm_clk    = r_pclk;
  assign pcm_data   = r_data;
  assign pcm_valid  = r_valid;
  assign overrun    = r_ovr;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: pattern and random PDM streams
// compared against a convolution model of the CIC response.
module tb_pdm_cic_decimator;

  localparam int CLK_DIV = 8;
  localparam int DECIM   = 16;
  localparam int OUT_W   = 12;
  localparam int LG      = $clog2(DECIM);
  localparam int SHIFT   = 3*LG - (OUT_W-1);
  localparam int PMAX    = (1 << (OUT_W-1)) - 1;
  localparam int PMIN    = -(1 << (OUT_W-1));
  localparam int PER     = CLK_DIV*DECIM;
  localparam int LAT     = CLK_DIV/2 + (3*DECIM-1)*CLK_DIV + 3;
  localparam int NB      = 512;
  localparam int KL      = 3*DECIM - 2;

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic             enable = 1'b0;
  logic             pdm_clk;
  logic             pdm_data = 1'b0;
  logic [OUT_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready = 1'b1;
  logic             overrun;
  logic             clr_overrun = 1'b0;
  logic [31:0]      sample_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int h2[2*DECIM-1];
  int h[KL];
  bit bits[NB];
  bit mon_on = 1'b0;
  bit prev_pc = 1'b0;
  bit prev_v = 1'b0;
  int bidx = 0;
  int en_cyc = 0;
  int run = 0;
  int n_xfer = 0;
  int n_rise = 0;
  int last_rise = 0;
  int first_lat = 0;
  int last_pcm = 0;

  pdm_cic_decimator #(
    .CLK_DIV(CLK_DIV),
    .DECIM(DECIM),
    .OUT_W(OUT_W)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .enable(enable),
    .pdm_clk(pdm_clk),
    .pdm_data(pdm_data),
    .pcm_data(pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overrun(overrun),
    .clr_overrun(clr_overrun),
    .sample_cnt(sample_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // k-th decimated result: boxcar^3 kernel over the captured +/-1 bits
  function automatic int model(input int k);
    int acc = 0;
    int n;
    for (int j = 0; j < KL; j++) begin
      n = k*DECIM - 3 - j;
      if (n >= 0 && n < NB)
        acc += h[j] * (bits[n] ? 1 : -1);
    end
    acc = acc >>> SHIFT;
    if (acc > PMAX) acc = PMAX;
    if (acc < PMIN) acc = PMIN;
    return acc;
  endfunction

  function automatic bit pat_bit(input int p, input int n);
    case (p)
      0: return 1'b1;
      1: return 1'b0;
      2: return (n % 2) == 0;
      3: return (n % 4) != 3;
      4: return n < 3*DECIM;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  always @(posedge ACLK) begin
    #1;
    if (!enable) begin
      bidx = 0;
      pdm_data = bits[0];
      en_cyc = 0;
      n_xfer = 0;
      n_rise = 0;
      run = 0;
      first_lat = 0;
    end else begin
      en_cyc++;
      if (mon_on && en_cyc == 1)
        check("pclk_first", pdm_clk, 1);
      if (pdm_clk != prev_pc) begin
        if (mon_on && en_cyc > 1) begin
          if (prev_pc) check("pclk_hi", run, CLK_DIV/2);
          else         check("pclk_lo", run, CLK_DIV/2);
        end
        run = 1;
      end else begin
        run++;
      end
      if (prev_pc && !pdm_clk && bidx < NB-1) begin
        bidx++;
        pdm_data = bits[bidx];
      end
      if (mon_on && pcm_valid && !prev_v) begin
        if (n_rise == 0) first_lat = en_cyc;
        else check("rate", en_cyc - last_rise, PER);
        last_rise = en_cyc;
        n_rise++;
      end
      if (mon_on && pcm_valid && pcm_ready) begin
        n_xfer++;
        last_pcm = $signed(pcm_data);
        check("pcm", last_pcm, model(n_xfer + 2));
      end
    end
    prev_pc = pdm_clk;
    prev_v  = pcm_valid;
  end

  task automatic run_pat(input int p, input int nsamp, input string tag);
    int t;
    logic [31:0] c0;
    @(negedge ACLK);
    mon_on = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < NB; i++) bits[i] = pat_bit(p, i);
    repeat (4) @(negedge ACLK);
    c0 = sample_cnt;
    pcm_ready = 1'b1;
    enable = 1'b1;
    mon_on = 1'b1;
    t = 0;
    while (n_xfer < nsamp && t < (nsamp+4)*PER) begin
      @(negedge ACLK);
      t++;
    end
    check({tag, "_n"}, n_xfer, nsamp);
    check({tag, "_lat"}, first_lat, LAT);
    repeat (2) @(negedge ACLK);
    check({tag, "_cnt"}, sample_cnt - c0, nsamp);
  endtask

  task automatic wait_valid(input int lim, input string tag);
    int t = 0;
    while (!pcm_valid && t < lim) begin
      @(negedge ACLK);
      t++;
    end
    check(tag, pcm_valid, 1);
  endtask

  initial begin
    int nbad;
    logic [31:0] c0;
    logic [OUT_W-1:0] held;

    for (int i = 0; i < 2*DECIM-1; i++) h2[i] = 0;
    for (int a = 0; a < DECIM; a++)
      for (int b = 0; b < DECIM; b++) h2[a+b]++;
    for (int i = 0; i < KL; i++) h[i] = 0;
    for (int a = 0; a < 2*DECIM-1; a++)
      for (int b = 0; b < DECIM; b++) h[a+b] += h2[a];
    for (int i = 0; i < NB; i++) bits[i] = 1'b0;

    repeat (3) @(negedge ACLK);
    check("rst_pclk", pdm_clk, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_data", pcm_data, 0);
    check("rst_ovr", overrun, 0);
    check("rst_cnt", sample_cnt, 0);
    ARESETN = 1'b1;
    nbad = 0;
    repeat (1000) begin
      @(negedge ACLK);
      if (pdm_clk || pcm_valid || sample_cnt != 0) nbad++;
    end
    check("idle", nbad, 0);

    run_pat(0, 6, "dc1");
    check("dc1_val", last_pcm, PMAX);
    run_pat(1, 6, "dc0");
    check("dc0_val", last_pcm, PMIN);
    run_pat(2, 6, "alt");
    check("alt_val", last_pcm, 0);
    run_pat(3, 6, "q31");
    check("q31_val", last_pcm, 1 << (OUT_W-2));
    run_pat(5, 12, "rnd");

    @(negedge ACLK);
    mon_on = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < NB; i++) bits[i] = pat_bit(4, i);
    pcm_ready = 1'b0;
    repeat (4) @(negedge ACLK);
    c0 = sample_cnt;
    enable = 1'b1;
    wait_valid(5*PER, "bp_valid");
    check("bp_first", $signed(pcm_data), model(3));
    check("bp_ovr0", overrun, 0);
    held = pcm_data;
    nbad = 0;
    repeat (PER+4) begin
      @(negedge ACLK);
      if (pcm_data != held || !pcm_valid) nbad++;
    end
    check("bp_hold", nbad, 0);
    check("bp_keep", $signed(pcm_data), model(3));
    check("bp_ovr", overrun, 1);
    pcm_ready = 1'b1;
    @(negedge ACLK);
    pcm_ready = 1'b0;
    @(negedge ACLK);
    check("bp_cnt", sample_cnt - c0, 1);
    check("bp_empty", pcm_valid, 0);
    clr_overrun = 1'b1;
    @(negedge ACLK);
    clr_overrun = 1'b0;
    check("bp_clr", overrun, 0);
    wait_valid(2*PER, "bp_valid2");
    check("bp_next", $signed(pcm_data), model(5));
    repeat (PER-1) @(negedge ACLK);
    clr_overrun = 1'b1;
    @(negedge ACLK);
    clr_overrun = 1'b0;
    check("bp_setwins", overrun, 1);

    repeat (PER/3) @(negedge ACLK);
    c0 = sample_cnt;
    enable = 1'b0;
    @(negedge ACLK);
    check("dis_valid", pcm_valid, 0);
    check("dis_pclk", pdm_clk, 0);
    check("dis_cnt", sample_cnt, c0);
    check("dis_ovr", overrun, 1);

    run_pat(0, 4, "re");
    check("re_val", last_pcm, PMAX);

    @(negedge ACLK);
    mon_on = 1'b0;
    pcm_ready = 1'b0;
    wait_valid(2*PER, "ar_valid");
    pcm_ready = 1'b1;
    #2 ARESETN = 1'b0;
    #1;
    check("ar_valid", pcm_valid, 0);
    check("ar_data", pcm_data, 0);
    check("ar_pclk", pdm_clk, 0);
    check("ar_ovr", overrun, 0);
    check("ar_cnt", sample_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
Front-end stage feeding the PDM_decoder AXI-Lite register block. It generates the microphone PDM clock and samples the 1-bit PDM stream. A 3rd-order CIC decimator (M=1) turns the stream into signed PCM samples. Samples are handed downstream over a valid/ready handshake, together with status (overrun flag, sample count) for the register map.

Parameters:
CLK_DIV, 50, ACLK cycles per pdm_clk period; even, >= 8 (100 MHz -> 2 MHz)
DECIM, 64, decimation ratio R; power of 2, 3*log2(DECIM) >= OUT_W-1
OUT_W, 16, PCM output width, signed

Ports:
ACLK  in  1  system clock
ARESETN  in  1  asynchronous active-low reset
enable  in  1  run control; low = idle and cleared
pdm_clk  out  1  clock to microphone
pdm_data  in  1  microphone data, asynchronous to ACLK
pcm_data  out  OUT_W  signed PCM sample
pcm_valid  out  1  pcm_data holds an unconsumed sample
pcm_ready  in  1  downstream accepts sample
overrun  out  1  sticky: a sample was dropped
clr_overrun  in  1  single-cycle pulse, clears overrun
sample_cnt  out  32  number of samples accepted downstream

Behaviour:
- Reset (ARESETN=0, async): pdm_clk=0, pcm_data=0, pcm_valid=0, overrun=0, sample_cnt=0. Divider, synchronizer, integrators, combs and warm-up counter are cleared.
- enable=0 has the same effect as reset on all state except sample_cnt and overrun, which hold. The synchronous clear is applied on the cycle enable is sampled low.
- Clock generation:
  - Divider counts 0..CLK_DIV-1.
  - pdm_clk=1 for counts 0..CLK_DIV/2-1 and 0 otherwise.
  - First pdm_clk rising edge comes on the cycle after enable rises.
- Input sampling:
  - pdm_data passes through a 2-FF synchronizer.
  - The synchronized bit is captured on the cycle with count = CLK_DIV/2-1 (last high-phase cycle, left-channel slot).
  - Mapping: 1 -> +1, 0 -> -1.
- Arithmetic: ACC_W = 3*log2(DECIM)+2 bits, two's complement.
  - Integrators update once per captured bit and wrap modulo 2^ACC_W; no saturation.
- Decimation:
  - A phase counter 0..DECIM-1 advances per captured bit.
  - When it wraps, the decimate strobe fires on the same ACLK cycle as the DECIM-th integrator update.
  - Strobe at cycle t -> the three comb stages are registered at t+1 -> the output candidate is formed at t+2.
- Output scaling:
  - Comb result range is [-DECIM^3, +DECIM^3].
  - Output = result >>> (3*log2(DECIM)-(OUT_W-1)), arithmetic shift, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Defaults: shift 3; +262144 -> +32767 (saturated); -262144 -> -32768.
- Warm-up: after reset or enable rising, the first 2 decimated results are discarded and never presented.
- Handshake: single output register.
  - Transfer occurs when pcm_valid && pcm_ready; sample_cnt increments by 1 on each transfer and wraps at 2^32.
  - pcm_data is stable while pcm_valid=1 and pcm_ready=0.
  - New candidate and output register empty, or transferring in the same cycle: load it; pcm_valid=1.
  - New candidate while pcm_valid=1 and pcm_ready=0: the new sample is dropped, the old sample is kept, overrun is set.
  - No candidate and transfer: pcm_valid drops to 0.
- overrun: clr_overrun clears it. If clear and a new drop occur in the same cycle, set wins (overrun=1).
- Latency: decimate strobe to pcm_valid rising = 2 ACLK cycles, when the output register is empty.
- Output rate: one sample per CLK_DIV*DECIM ACLK cycles (defaults: 3200 cycles, 31.25 kS/s).

Test Plan:
- Reset/idle: ARESETN=0 then 1 with enable=0 for 1000 cycles -> pdm_clk=0, pcm_valid=0, sample_cnt=0 throughout.
- Clock and rate: enable=1, defaults -> pdm_clk high 25 / low 25 cycles. pcm_valid rising edges are 3200 cycles apart; the first 2 decimated results are not presented.
- DC full scale: pdm_data=1 constant, pcm_ready=1 -> emitted samples 4 onward equal +32767 (saturated). pdm_data=0 constant -> samples 4 onward equal -32768.
- Mid-scale: pdm_data alternating 1,0 per pdm_clk period -> samples 4 onward equal 0. With 3 ones : 1 zero repeating -> samples 4 onward equal +16384.
- Backpressure/overrun: pcm_ready=0 across two decimation periods -> pcm_data holds the first sample, overrun=1, the second sample is lost. Then pcm_ready=1 -> one transfer, sample_cnt +1. clr_overrun pulse -> overrun=0. Clear coinciding with a new drop -> overrun stays 1.
- Mid-operation disable: drop enable mid-frame -> next cycle pcm_valid=0 and pdm_clk=0; sample_cnt holds. Re-enable with constant-1 input -> the warm-up discard repeats, then samples 4 onward equal +32767. Async ARESETN assertion mid-transfer clears all outputs immediately.
